// File: rtl/tx_access_code.sv
// Transmit access-code serializer: 4-bit preamble, 64-bit sync word (LSB first) and an optional 4-bit trailer.
// Defining TXAC_ABORT_EN adds a tx_abort input that drops an in-flight frame without a tx_done.
module tx_access_code #(
  parameter int PRE_LEN = 4,
  parameter int TRL_LEN = 4
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        p_1us,
  input  logic        tx_start,
  input  logic [63:0] ref_sync,
  input  logic        trailer_en,
`ifdef TXAC_ABORT_EN
  input  logic        tx_abort,
`endif
  output logic        txbit,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [1:0]  tx_phase
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SYNC = 2'd2,
    TRL  = 2'd3
  } phase_t;

  localparam logic [6:0] PRE_LAST  = 7'(PRE_LEN - 1);
  localparam logic [6:0] SYNC_LAST = 7'(PRE_LEN + 64 - 1);
  localparam logic [6:0] TRL_LAST  = 7'(PRE_LEN + 64 + TRL_LEN - 1);

  phase_t      state;
  logic [63:0] sreg;
  logic [6:0]  bitcnt;
  logic        trl;
  logic        abort_req;

`ifdef TXAC_ABORT_EN
  assign abort_req = tx_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign tx_phase = state;

  // Preamble and trailer alternate, so each starts from a known bit and toggles per tick;
  // the sync-to-trailer hand-off inverts the last sync bit (s63) to get ~s63.
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= 64'd0;
      bitcnt  <= 7'd0;
      trl     <= 1'b0;
      txbit   <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (abort_req) begin
        state   <= IDLE;
        bitcnt  <= 7'd0;
        txbit   <= 1'b0;
        tx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tx_start) begin
              sreg    <= ref_sync;
              trl     <= trailer_en;
              bitcnt  <= 7'd0;
              txbit   <= ref_sync[0];
              tx_busy <= 1'b1;
              state   <= PRE;
            end else begin
              txbit   <= 1'b0;
              tx_busy <= 1'b0;
            end
          end
          PRE: begin
            if (p_1us) begin
              bitcnt <= bitcnt + 7'd1;
              if (bitcnt == PRE_LAST) begin
                txbit <= sreg[0];
                state <= SYNC;
              end else begin
                txbit <= ~txbit;
              end
            end
          end
          SYNC: begin
            if (p_1us) begin
              sreg <= {1'b0, sreg[63:1]};
              if (bitcnt == SYNC_LAST) begin
                if (trl) begin
                  bitcnt <= bitcnt + 7'd1;
                  txbit  <= ~txbit;
                  state  <= TRL;
                end else begin
                  bitcnt  <= 7'd0;
                  txbit   <= 1'b0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                  state   <= IDLE;
                end
              end else begin
                bitcnt <= bitcnt + 7'd1;
                txbit  <= sreg[1];
              end
            end
          end
          TRL: begin
            if (p_1us) begin
              if (bitcnt == TRL_LAST) begin
                bitcnt  <= 7'd0;
                txbit   <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                state   <= IDLE;
              end else begin
                bitcnt <= bitcnt + 7'd1;
                txbit  <= ~txbit;
              end
            end
          end
          default: begin
            state   <= IDLE;
            bitcnt  <= 7'd0;
            txbit   <= 1'b0;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_access_code.sv
// Self-checking bench for tx_access_code: frame-level reference model compared every cycle,
// plus directed literal checks for preamble/sync/trailer, loopback, restart, reset and abort.
module tb_tx_access_code;

  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        p_1us = 1'b0;
  logic        tx_start = 1'b0;
  logic        trailer_en = 1'b0;
  logic [63:0] ref_sync = 64'd0;
  logic        txbit, tx_busy, tx_done;
  logic [1:0]  tx_phase;
`ifdef TXAC_ABORT_EN
  logic        tx_abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [63:0] SYNC_A = 64'h0123_4567_89AB_CDEF;

  tx_access_code dut (
    .clk_6M    (clk_6M),
    .rst       (rst),
    .p_1us     (p_1us),
    .tx_start  (tx_start),
    .ref_sync  (ref_sync),
    .trailer_en(trailer_en),
`ifdef TXAC_ABORT_EN
    .tx_abort  (tx_abort),
`endif
    .txbit     (txbit),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_phase  (tx_phase)
  );

  always #5 clk_6M = ~clk_6M;

  // Reference model: the whole frame is built as a bit list at start; a pointer walks it per tick.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_idx = 0;
  int m_len = 68;
  bit m_frame [72];

  always @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
`ifdef TXAC_ABORT_EN
      if (tx_abort) m_busy = 1'b0; else
`endif
      if (m_busy) begin
        if (p_1us) begin
          if (m_idx == m_len - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else if (tx_start) begin
        for (int i = 0; i < 4; i++) m_frame[i] = ref_sync[0] ^ (i % 2 == 1);
        for (int i = 0; i < 64; i++) m_frame[4 + i] = ref_sync[i];
        for (int i = 0; i < 4; i++) m_frame[68 + i] = ~ref_sync[63] ^ (i % 2 == 1);
        m_len  = trailer_en ? 72 : 68;
        m_idx  = 0;
        m_busy = 1'b1;
      end
    end
  end

  function automatic logic [4:0] expected_out();
    logic [1:0] ph;
    if (!m_busy) return {1'b0, 1'b0, m_done, 2'd0};
    ph = (m_idx < 4) ? 2'd1 : (m_idx < 68) ? 2'd2 : 2'd3;
    return {m_frame[m_idx], 1'b1, 1'b0, ph};
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      logic [4:0] exp_v, act_v;
      @(negedge clk_6M);
      exp_v = expected_out();
      act_v = {txbit, tx_busy, tx_done, tx_phase};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t {txbit,busy,done,phase} actual=%b required=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #2;
  endtask

  // Starts a frame now and clocks it out; captures the bit held before each tick.
  task automatic run_frame(input logic [63:0] sync, input bit trl, input bit rnd,
                           input int busy_start_at, input int abort_at,
                           output logic [71:0] cap, output logic [63:0] rx,
                           output int npulse, output bit done_seen);
    ref_sync   = sync;
    trailer_en = trl;
    tx_start   = 1'b1;
    p_1us      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    tx_start  = 1'b0;
    p_1us     = 1'b0;
    cap       = '0;
    rx        = '0;
    npulse    = 0;
    done_seen = 1'b0;
    for (int g = 0; g < 100 && !done_seen; g++) begin
      int gap;
      gap = rnd ? int'($urandom_range(1, 4)) : 5;
      for (int k = 0; k < gap; k++) begin
        if (npulse == busy_start_at && k == 0) tx_start = 1'b1;
        else if (rnd && $urandom_range(0, 7) == 0) tx_start = 1'b1;
        if (rnd) begin
          ref_sync   = {$urandom, $urandom};
          trailer_en = 1'($urandom_range(0, 1));
        end
        tick();
        tx_start = 1'b0;
      end
      if (npulse < 72) cap[npulse] = txbit;
      rx    = {txbit, rx[63:1]};
      p_1us = 1'b1;
`ifdef TXAC_ABORT_EN
      if (npulse == abort_at) tx_abort = 1'b1;
`endif
      npulse++;
      tick();
      p_1us = 1'b0;
`ifdef TXAC_ABORT_EN
      tx_abort = 1'b0;
`endif
      if (tx_done) done_seen = 1'b1;
      else if (!tx_busy) break;
    end
  endtask

  initial begin
    logic [71:0] cap;
    logic [63:0] rx;
    logic [63:0] sync_b;
    int          np;
    bit          dn;
    bit          trl;
    bit          done_any;

    repeat (3) tick();
    check("reset_outputs", 72'({txbit, tx_busy, tx_done, tx_phase}), 72'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", 72'({txbit, tx_busy, tx_done, tx_phase}), 72'd0);

    // Plain frame, also fed through an RX-style shift register
    run_frame(SYNC_A, 1'b0, 1'b0, -1, -1, cap, rx, np, dn);
    check("t1_preamble", 72'(cap[3:0]), 72'(4'b0101));
    check("t1_sync_bits", 72'(cap[67:4]), 72'(SYNC_A));
    check("t1_pulse_count", 72'(np), 72'd68);
    check("t1_done_seen", 72'(dn), 72'd1);
    check("t3_loopback", 72'(rx), 72'(SYNC_A));

    // Same frame with trailer
    repeat (2) tick();
    run_frame(SYNC_A, 1'b1, 1'b0, -1, -1, cap, rx, np, dn);
    check("t2_preamble", 72'(cap[3:0]), 72'(4'b0101));
    check("t2_trailer", 72'(cap[71:68]), 72'(4'b0101));
    check("t2_pulse_count", 72'(np), 72'd72);
    check("t2_done_seen", 72'(dn), 72'd1);

    // Start while busy ignored; start in the done cycle begins the next frame
    repeat (2) tick();
    run_frame(~SYNC_A, 1'b0, 1'b0, 20, -1, cap, rx, np, dn);
    check("t4_busy_start_ignored", 72'(np), 72'd68);
    check("t4_first_done", 72'(dn), 72'd1);
    sync_b = {$urandom, $urandom};
    run_frame(sync_b, 1'b0, 1'b0, -1, -1, cap, rx, np, dn);
    check("t4_second_frame_sync", 72'(cap[67:4]), 72'(sync_b));
    check("t4_second_frame_pre0", 72'(cap[0]), 72'(sync_b[0]));
    check("t4_second_done", 72'(dn), 72'd1);

    // Asynchronous reset mid-frame at bit 40
    repeat (2) tick();
    ref_sync   = {$urandom, $urandom};
    trailer_en = 1'b1;
    tx_start   = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      repeat (2) tick();
      p_1us = 1'b1;
      tick();
      p_1us = 1'b0;
    end
    check("t5_phase_before_reset", 72'(tx_phase), 72'd2);
    #1 rst = 1'b1;
    #1;
    check("t5_async_reset_outputs", 72'({txbit, tx_busy, tx_done, tx_phase}), 72'd0);
    tick();
    rst      = 1'b0;
    done_any = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p_1us = (i % 3 == 0);
      tick();
      done_any = done_any | tx_done | tx_busy;
    end
    p_1us = 1'b0;
    check("t5_stays_idle", 72'({done_any, tx_phase}), 72'd0);

`ifdef TXAC_ABORT_EN
    run_frame(SYNC_A, 1'b1, 1'b0, -1, 30, cap, rx, np, dn);
    check("t6_abort_pulses", 72'(np), 72'd31);
    check("t6_abort_no_done", 72'(dn), 72'd0);
    check("t6_abort_outputs", 72'({txbit, tx_busy, tx_phase}), 72'd0);
`endif

    // Randomized frames with mid-frame input noise and random spacing
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 3)) tick();
      trl = 1'($urandom_range(0, 1));
      run_frame({$urandom, $urandom}, trl, 1'b1, -1, -1, cap, rx, np, dn);
      check("rnd_pulse_count", 72'(np), trl ? 72'd72 : 72'd68);
      check("rnd_done_seen", 72'(dn), 72'd1);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
